add100_accum: RTL and testbench

Sequential accumulator stage placed directly downstream of the 100-bit ripple-carry adder. It accepts a stream of 100-bit words over a valid/ready handshake and feeds each word, together with the running sum, into a 100-bit full-adder chain (cin tied 0). It counts carry-outs from bit 99 as overflow events. At end of packet it presents the final sum, word count and overflow count on a valid/ready output.

---
 rtl/add100_accum.sv | 100 ++++++++++
 tb/tb_add100_accum.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add100_accum.sv
// add100_accum: packet accumulator that sits after the 100-bit ripple-carry adder.
// Each accepted word is added into a running sum through a full-adder chain
// with cin tied to 0. Carry-outs from the top bit are counted as overflow events,
// and the count saturates. The sum, word count and overflow count are presented
// on a valid/ready output when the packet ends. A packet ends on in_last or
// when it reaches MAX_LEN words.
module add100_accum #(
   parameter int WIDTH   = 100,
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 5,
   parameter int OVF_W   = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic [CNT_W-1:0] out_len,
   output logic [OVF_W-1:0] out_ovf
);

   typedef enum logic {
      ST_ACC = 1'b0,
      ST_OUT = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] len;
   logic [OVF_W-1:0] ovf;

   logic [WIDTH-1:0] add_sum;
   logic             add_cout;
   logic [CNT_W-1:0] len_inc;
   logic             end_pkt;

   // Full-adder chain: acc + in_data with cin = 0. Only the final carry leaves this block.
   always_comb begin : adder_chain
      logic c;
      // NOTE: blocking assignments are used here on purpose. Each stage's carry must be
      // visible to the next stage within the same evaluation of the loop.
      c       = 1'b0;
      add_sum = '0;
      for (int i = 0; i < WIDTH; i++) begin
         add_sum[i] = acc[i] ^ in_data[i] ^ c;
         c          = (acc[i] & in_data[i]) | (c & (acc[i] ^ in_data[i]));
      end
      add_cout = c;
   end

   assign len_inc = len + 1'b1;
   assign end_pkt = in_last || (len_inc == CNT_W'(MAX_LEN));

   // Control and datapath state. Words are accepted in ACC. The result is held in OUT until it is drained.
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignments only. That way every register
      // here samples its inputs from before the clock edge.
      if (!resetn) begin
         state <= ST_ACC;
         acc   <= '0;
         len   <= '0;
         ovf   <= '0;
      end else begin
         case (state)
            ST_ACC: begin
               if (in_valid) begin
                  acc <= add_sum;
                  len <= len_inc;
                  if (add_cout && (ovf != {OVF_W{1'b1}}))
                     ovf <= ovf + 1'b1;
                  if (end_pkt)
                     state <= ST_OUT;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  acc   <= '0;
                  len   <= '0;
                  ovf   <= '0;
                  state <= ST_ACC;
               end
            end
            default: state <= ST_ACC;
         endcase
      end
   end

   // Handshakes are decoded from the state register alone. Results come straight from the
   // registers, so no input reaches an output combinationally.
   assign in_ready  = (state == ST_ACC);
   assign out_valid = (state == ST_OUT);
   assign out_sum   = acc;
   assign out_len   = len;
   assign out_ovf   = ovf;

endmodule

// File: tb/tb_add100_accum.sv
// Testbench for add100_accum. Directed scenarios plus randomized packets, all checked
// against a plain-arithmetic packet model. A second instance with a narrow overflow
// counter exercises saturation.
module tb_add100_accum;

   localparam int W     = 100;
   localparam int CNT_W = 5;
   localparam int OVF_W = 8;

   logic          clk;
   logic          resetn;
   logic          in_valid, in_ready, in_last;
   logic [W-1:0]  in_data;
   logic          out_valid, out_ready;
   logic [W-1:0]  out_sum;
   logic [CNT_W-1:0] out_len;
   logic [OVF_W-1:0] out_ovf;

   // narrow-overflow instance: OVF_W=4, MAX_LEN=20
   logic          in_valid2, in_ready2, in_last2;
   logic [W-1:0]  in_data2;
   logic          out_valid2, out_ready2;
   logic [W-1:0]  out_sum2;
   logic [CNT_W-1:0] out_len2;
   logic [3:0]    out_ovf2;

   int passed = 0;
   int total  = 0;

   add100_accum #(.WIDTH(W), .MAX_LEN(16), .CNT_W(CNT_W), .OVF_W(OVF_W)) dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_len(out_len), .out_ovf(out_ovf)
   );

   add100_accum #(.WIDTH(W), .MAX_LEN(20), .CNT_W(CNT_W), .OVF_W(4)) dut2 (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
      .out_valid(out_valid2), .out_ready(out_ready2),
      .out_sum(out_sum2), .out_len(out_len2), .out_ovf(out_ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
      $fatal(1);
   end

   // Reference: a packet's result from plain wide arithmetic. Each word adds into a
   // 101-bit value, and bit 100 is that word's carry.
   function automatic void model(input logic [W-1:0] words [$], input int ovf_max,
                                 output logic [W-1:0] s, output int len, output int ovf);
      logic [W:0] t;
      s   = '0;
      ovf = 0;
      len = words.size();
      foreach (words[i]) begin
         t = {1'b0, s} + {1'b0, words[i]};
         s = t[W-1:0];
         if (t[W] && ovf < ovf_max) ovf++;
      end
   endfunction

   function automatic logic [W-1:0] rand_word();
      logic [127:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) r = '1;
      return r[W-1:0];
   endfunction

   // Present one word and hold it until it is accepted. Returns at posedge+1.
   task automatic send(input logic [W-1:0] d, input logic last);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      @(negedge clk);
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      total++;
      if (guard >= 200)
         $display("FAIL send_timeout: in_ready=%b required=1", in_ready);
      else
         passed++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Wait for a result (bounded), capture it, then drain it with a single out_ready cycle.
   task automatic collect(output logic [W-1:0] s, output int len, output int ovf, output bit got);
      int guard;
      guard = 0;
      while (!out_valid && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      got = out_valid;
      s   = out_sum;
      len = int'(out_len);
      ovf = int'(out_ovf);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #12;
      total++;
      if ({in_ready, out_valid, out_sum, out_len, out_ovf} !== {1'b1, 1'b0, {W{1'b0}}, 5'd0, 8'd0})
         $display("FAIL reset_state: rdy=%b vld=%b sum=%h len=%0d ovf=%0d required rdy=1 vld=0 zeros",
                  in_ready, out_valid, out_sum, out_len, out_ovf);
      else passed++;
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      send(W'(1), 1'b0);
      send(W'(2), 1'b0);
      send(W'(3), 1'b1);
      total++;
      if ({out_valid, in_ready, out_sum, out_len, out_ovf} !== {1'b1, 1'b0, W'(6), 5'd3, 8'd0})
         $display("FAIL basic_result: vld=%b rdy=%b sum=%0h len=%0d ovf=%0d required vld=1 rdy=0 sum=6 len=3 ovf=0",
                  out_valid, in_ready, out_sum, out_len, out_ovf);
      else passed++;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      total++;
      if ({out_valid, in_ready, out_sum, out_len, out_ovf} !== {1'b0, 1'b1, {W{1'b0}}, 5'd0, 8'd0})
         $display("FAIL basic_drain: vld=%b rdy=%b sum=%0h len=%0d ovf=%0d required vld=0 rdy=1 zeros",
                  out_valid, in_ready, out_sum, out_len, out_ovf);
      else passed++;
   endtask

   task automatic test_overflow();
      logic [W-1:0] s;
      int len, ovf;
      bit got;
      send({W{1'b1}}, 1'b0);
      send(W'(2), 1'b1);
      collect(s, len, ovf, got);
      total++;
      if (!got || s !== W'(1) || len != 2 || ovf != 1)
         $display("FAIL overflow: got=%b sum=%0h len=%0d ovf=%0d required sum=1 len=2 ovf=1", got, s, len, ovf);
      else passed++;
   endtask

   task automatic test_maxlen();
      logic [W-1:0] s;
      int len, ovf;
      bit got;
      for (int i = 0; i < 15; i++) send(W'(5), 1'b0);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL maxlen_early: vld=%b rdy=%b required vld=0 rdy=1 after 15 words", out_valid, in_ready);
      else passed++;
      send(W'(5), 1'b0);
      total++;
      if ({out_valid, in_ready, out_sum, out_len} !== {1'b1, 1'b0, W'(80), 5'd16})
         $display("FAIL maxlen_force: vld=%b rdy=%b sum=%0d len=%0d required vld=1 rdy=0 sum=80 len=16",
                  out_valid, in_ready, out_sum, out_len);
      else passed++;
      collect(s, len, ovf, got);
   endtask

   task automatic test_backpressure();
      logic [W-1:0] q [$];
      logic [W-1:0] e_sum, s;
      int e_len, e_ovf, len, ovf;
      bit got, stable;
      q = '{W'(100'h123456789), {W{1'b1}}};
      model(q, 255, e_sum, e_len, e_ovf);
      send(q[0], 1'b0);
      send(q[1], 1'b1);
      // new word waiting while the result is held
      in_valid = 1'b1;
      in_data  = W'(7);
      in_last  = 1'b1;
      stable   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if ({out_valid, in_ready, out_sum, out_len, out_ovf} !== {1'b1, 1'b0, e_sum, 5'(e_len), 8'(e_ovf)})
            stable = 1'b0;
      end
      total++;
      if (!stable)
         $display("FAIL backpressure_hold: vld=%b rdy=%b sum=%h len=%0d ovf=%0d required vld=1 rdy=0 sum=%h len=%0d ovf=%0d",
                  out_valid, in_ready, out_sum, out_len, out_ovf, e_sum, e_len, e_ovf);
      else passed++;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      total++;
      if ({out_valid, in_ready, out_sum} !== {1'b0, 1'b1, {W{1'b0}}})
         $display("FAIL backpressure_drain: vld=%b rdy=%b sum=%h required vld=0 rdy=1 sum=0",
                  out_valid, in_ready, out_sum);
      else passed++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      collect(s, len, ovf, got);
      total++;
      if (!got || s !== W'(7) || len != 1 || ovf != 0)
         $display("FAIL backpressure_next: got=%b sum=%0h len=%0d ovf=%0d required sum=7 len=1 ovf=0", got, s, len, ovf);
      else passed++;
   endtask

   task automatic test_saturation();
      logic [W-1:0] q [$];
      logic [W-1:0] e_sum, s;
      int e_len, e_ovf, len, ovf, left, n;
      bit got;
      left = 300;
      while (left > 0) begin
         n = (left >= 16) ? 16 : left;
         q.delete();
         for (int i = 0; i < n; i++) begin
            q.push_back({W{1'b1}});
            send({W{1'b1}}, (i == n - 1) && (n < 16));
         end
         left -= n;
         model(q, 255, e_sum, e_len, e_ovf);
         collect(s, len, ovf, got);
         total++;
         if (!got || s !== e_sum || len != e_len || ovf != e_ovf)
            $display("FAIL saturation_pkt: got=%b sum=%h len=%0d ovf=%0d required sum=%h len=%0d ovf=%0d",
                     got, s, len, ovf, e_sum, e_len, e_ovf);
         else passed++;
      end
   endtask

   task automatic test_sat_narrow();
      logic [W-1:0] q [$];
      logic [W-1:0] e_sum;
      int e_len, e_ovf;
      int sizes [2] = '{16, 20};
      for (int p = 0; p < 2; p++) begin
         q.delete();
         for (int i = 0; i < sizes[p]; i++) begin
            q.push_back({W{1'b1}});
            in_valid2 = 1'b1;
            in_data2  = {W{1'b1}};
            in_last2  = (p == 0) && (i == sizes[p] - 1);
            @(posedge clk);
            #1;
         end
         in_valid2 = 1'b0;
         in_last2  = 1'b0;
         model(q, 15, e_sum, e_len, e_ovf);
         total++;
         if ({out_valid2, out_sum2, out_len2, out_ovf2} !== {1'b1, e_sum, 5'(e_len), 4'(e_ovf)})
            $display("FAIL sat_narrow_%0d: vld=%b sum=%h len=%0d ovf=%0d required vld=1 sum=%h len=%0d ovf=%0d",
                     p, out_valid2, out_sum2, out_len2, out_ovf2, e_sum, e_len, e_ovf);
         else passed++;
         out_ready2 = 1'b1;
         @(posedge clk);
         #1;
         out_ready2 = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] s;
      int len, ovf;
      bit got;
      send(W'(7), 1'b0);
      send(W'(9), 1'b0);
      #3;
      resetn = 1'b0;
      #1;
      total++;
      if ({in_ready, out_valid, out_sum, out_len, out_ovf} !== {1'b1, 1'b0, {W{1'b0}}, 5'd0, 8'd0})
         $display("FAIL reset_mid: rdy=%b vld=%b sum=%h len=%0d ovf=%0d required rdy=1 vld=0 zeros",
                  in_ready, out_valid, out_sum, out_len, out_ovf);
      else passed++;
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk);
      #1;
      send(W'(4), 1'b1);
      collect(s, len, ovf, got);
      total++;
      if (!got || s !== W'(4) || len != 1 || ovf != 0)
         $display("FAIL reset_mid_next: got=%b sum=%0h len=%0d ovf=%0d required sum=4 len=1 ovf=0", got, s, len, ovf);
      else passed++;
   endtask

   task automatic test_random();
      logic [W-1:0] q [$];
      logic [W-1:0] e_sum, s, w;
      int e_len, e_ovf, len, ovf, n;
      bit got, last;
      for (int p = 0; p < 30; p++) begin
         n = $urandom_range(1, 16);
         q.delete();
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            w    = rand_word();
            last = (i == n - 1) && ((n < 16) || ($urandom_range(0, 1) == 1));
            q.push_back(w);
            send(w, last);
         end
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         model(q, 255, e_sum, e_len, e_ovf);
         collect(s, len, ovf, got);
         total++;
         if (!got || s !== e_sum || len != e_len || ovf != e_ovf)
            $display("FAIL random_pkt_%0d: got=%b sum=%h len=%0d ovf=%0d required sum=%h len=%0d ovf=%0d",
                     p, got, s, len, ovf, e_sum, e_len, e_ovf);
         else passed++;
      end
   endtask

   initial begin
      in_valid   = 1'b0;
      in_data    = '0;
      in_last    = 1'b0;
      out_ready  = 1'b0;
      in_valid2  = 1'b0;
      in_data2   = '0;
      in_last2   = 1'b0;
      out_ready2 = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_maxlen();
      test_backpressure();
      test_saturation();
      test_sat_narrow();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
